pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/hazard_stats.sv | 36 +++
 rtl/pipeline_hazard_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encodings, flush-length default, counter width and the load-use test.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2,
        MWAIT  = 2'd3
    } hz_state_t;

    localparam int FLUSH_CYCLES_DEF = 2;
    localparam int CNT_W            = 3;

    // True when the ID instruction reads the register a pending load in EX writes.
    function automatic logic load_use_hit(
        input logic       ex_valid,
        input logic       ex_mem_read,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs1,
        input logic       id_rs1_used,
        input logic [4:0] id_rs2,
        input logic       id_rs2_used
    );
        return ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
               ((id_rs1_used && (id_rs1 == ex_rd)) ||
                (id_rs2_used && (id_rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/hazard_stats.sv
// Free-running 32-bit stall statistics: one counter per stall kind,
// each advancing once per cycle its stall is asserted and wrapping at 2^32.
module hazard_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_stall,
    input  logic        branch_stall,
    input  logic        pipe_freeze,
    output logic [31:0] stall_load_cnt,
    output logic [31:0] stall_branch_cnt,
    output logic [31:0] stall_mem_cnt
);

    logic [2:0]  event_vec;
    logic [31:0] count_reg [3];

    assign event_vec = {pipe_freeze, branch_stall, load_stall};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            // Count cycles in which this stall kind is active.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg[gi] <= 32'd0;
                end else if (event_vec[gi]) begin
                    count_reg[gi] <= count_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign stall_load_cnt   = count_reg[0];
    assign stall_branch_cnt = count_reg[1];
    assign stall_mem_cnt    = count_reg[2];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch redirect flush and
// data-memory wait freeze for a classic 5-stage pipeline.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        load_stall,
    output logic        branch_stall,
    output logic        id_ex_flush,
    output logic        pc_hold,
    output logic        pipe_freeze,
`ifdef HAZARD_STATS_EN
    output logic [31:0] stall_load_cnt,
    output logic [31:0] stall_branch_cnt,
    output logic [31:0] stall_mem_cnt,
`endif
    output logic [1:0]  state
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    hz_state_t        state_reg, state_next;
    hz_state_t        saved_reg, saved_next;
    hz_state_t        eff_state;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             mem_wait;
    logic             hz;

    assign mem_wait = dmem_req & ~dmem_ready;
    assign hz       = load_use_hit(ex_valid, ex_mem_read, ex_rd,
                                   id_rs1, id_rs1_used, id_rs2, id_rs2_used);
    assign state    = state_reg;

    // State, flush counter and the state parked during a memory wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            saved_reg <= RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            saved_reg <= saved_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state and stall outputs. The cycle that ends a memory wait is
    // handled as a normal cycle of the parked state, so a flush keeps
    // squashing and a redirect held through the wait is acted on then.
    always_comb begin
        state_next   = state_reg;
        saved_next   = saved_reg;
        cnt_next     = cnt_reg;
        load_stall   = 1'b0;
        branch_stall = 1'b0;
        id_ex_flush  = 1'b0;
        pc_hold      = 1'b0;
        pipe_freeze  = 1'b0;
        eff_state    = (state_reg == MWAIT) ? saved_reg : state_reg;

        if (!rst_n) begin
            // Outputs forced low while reset is held.
            state_next = RUN;
        end else if (mem_wait) begin
            pipe_freeze = 1'b1;
            pc_hold     = 1'b1;
            state_next  = MWAIT;
            if (state_reg != MWAIT) begin
                saved_next = state_reg;
            end
        end else begin
            saved_next = RUN;
            unique case (eff_state)
                FLUSH: begin
                    // EX holds a bubble here, so a redirect is ignored.
                    branch_stall = 1'b1;
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                    state_next = (cnt_reg <= CNT_W'(1)) ? RUN : FLUSH;
                end
                RUN, LSTALL: begin
                    if (ex_redirect) begin
                        branch_stall = 1'b1;
                        id_ex_flush  = 1'b1;
                        cnt_next     = CNT_LOAD;
                        state_next   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                    end else if ((eff_state == RUN) && hz) begin
                        load_stall  = 1'b1;
                        pc_hold     = 1'b1;
                        id_ex_flush = 1'b1;
                        state_next  = LSTALL;
                    end else begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    hazard_stats u_stats (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_stall       (load_stall),
        .branch_stall     (branch_stall),
        .pipe_freeze      (pipe_freeze),
        .stall_load_cnt   (stall_load_cnt),
        .stall_branch_cnt (stall_branch_cnt),
        .stall_mem_cnt    (stall_mem_cnt)
    );
`endif

endmodule
